// File: rtl/alu_pkg.sv
// Shared types and sizing for the bit-serial (16-bit slice) 64-bit ALU.
package alu_pkg;

   localparam int SLICE_W    = 16;
   localparam int NUM_SLICES = 4;
   localparam int DATA_W     = SLICE_W * NUM_SLICES;
   localparam int CNT_W      = $clog2(NUM_SLICES);

   typedef enum logic [1:0] {
      OP_NOR = 2'b00,
      OP_XOR = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu16bit_slice.sv
// Combinational 16-bit NOR/XOR/ADD/SUB slice, time-shared by the serial ALU.
module alu16bit_slice
   import alu_pkg::*;
#(
   parameter int DATA_W = SLICE_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   input  alu_op_e           op,
   output logic [DATA_W-1:0] s,
   output logic              cout
);

   logic [DATA_W:0] sum;

   always_comb begin
      sum  = '0;
      s    = '0;
      cout = 1'b0;
      case (op)
         OP_NOR: s = ~(a | b);
         OP_XOR: s = a ^ b;
         OP_ADD: begin
            sum       = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
            {cout, s} = sum;
         end
         OP_SUB: begin
            // Two's-complement subtract; cin=1 gives a-b, cin=0 gives a-b-1.
            sum       = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, cin};
            {cout, s} = sum;
         end
         default: s = '0;
      endcase
   end

endmodule

// File: rtl/alu64bit_serial.sv
// 64-bit ALU processing one 16-bit slice per cycle, LSB slice first.
// Optional: define ALU_SERIAL_ZERO_FLAG_EN to add the per-slice accumulated zero output.
module alu64bit_serial
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   input  logic [1:0]        op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] s,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   output logic              zero,
`endif
   output logic              cout
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   a_r, b_r;
   alu_op_e             op_r;
   logic                carry_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [SLICE_W-1:0]  slice_s;
   logic                slice_cout;
   logic                accept;
   logic                last_slice;

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign accept     = in_valid && in_ready;
   assign last_slice = (cnt_r == CNT_W'(NUM_SLICES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)   state_d = ST_BUSY;
         ST_BUSY: if (last_slice) state_d = ST_DONE;
         ST_DONE: if (out_ready)  state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Operand capture: pure data, loaded only on acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_r  <= a;
         b_r  <= b;
         op_r <= alu_op_e'(op);
      end
   end

   alu16bit_slice #(.DATA_W(SLICE_W)) u_slice (
      .a    (a_r[cnt_r*SLICE_W +: SLICE_W]),
      .b    (b_r[cnt_r*SLICE_W +: SLICE_W]),
      .cin  (carry_r),
      .op   (op_r),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // Slice sequencing: carry ripples through carry_r between cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s       <= '0;
         cout    <= 1'b0;
         cnt_r   <= '0;
         carry_r <= 1'b0;
      end else if (accept) begin
         cnt_r   <= '0;
         carry_r <= cin;
      end else if (state_q == ST_BUSY) begin
         s[cnt_r*SLICE_W +: SLICE_W] <= slice_s;
         carry_r <= slice_cout;
         cnt_r   <= cnt_r + 1'b1;
         if (last_slice) cout <= slice_cout;
      end
   end

`ifdef ALU_SERIAL_ZERO_FLAG_EN
   logic zacc_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zacc_r <= 1'b0;
         zero   <= 1'b0;
      end else if (accept) begin
         zacc_r <= 1'b1;
      end else if (state_q == ST_BUSY) begin
         zacc_r <= zacc_r & (slice_s == '0);
         if (last_slice) zero <= zacc_r & (slice_s == '0);
      end
   end
`endif

endmodule

// File: doc/alu64bit_serial.md
ALU64BIT_SERIAL -- requirements
Module: alu64bit_serial

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset: the clock is clk and the reset is rst_n.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- a  in  64  operand A
- b  in  64  operand B
- cin  in  1  carry in
- op  in  2  operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  64  result
- cout  out  1  carry out

Function
REQ-003 Op encoding SHALL be:
- 00: NOR, s = ~(a|b)
- 01: XOR, s = a^b
- 10: ADD, {cout,s} = a+b+cin
- 11: SUB, {cout,s} = a+~b+cin
REQ-004 For NOR and XOR, cout SHALL be 0.
REQ-005 The FSM SHALL have three states with these transitions:
- IDLE -> BUSY on in_valid && in_ready.
- BUSY -> DONE after 4 slice cycles.
- DONE -> IDLE on out_valid && out_ready.
REQ-006 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-007 On acceptance (edge N), the block SHALL register a, b, cin and op.
- Later input changes SHALL have no effect until the next acceptance.
REQ-008 Data SHALL be processed in 16-bit slices, LSB slice first.
- Slice k (bits 16k+15:16k) SHALL be written to s at edge N+1+k, for k=0..3.
REQ-009 The carry out of slice k SHALL be registered and used as the carry in of slice k+1.
- Slice 0 SHALL use the captured cin.
REQ-010 At edge N+4, the final slice carry SHALL be written to cout and the FSM SHALL enter DONE.
- out_valid SHALL be 1 from edge N+4, giving a latency of 4 cycles from acceptance.
REQ-011 In DONE, s and cout SHALL hold stable until the result is accepted.
REQ-012 In DONE, in_valid SHALL be ignored; a request and a result SHALL never complete in the same cycle.
REQ-013 s and cout SHALL be undefined-free (hold their last values) while in IDLE and BUSY.
- They SHALL be observed only when out_valid is 1.
REQ-014 After DONE -> IDLE, in_ready SHALL be 1 in the next cycle, giving a throughput of one operation per 6 cycles with out_ready tied to 1.

Reset
REQ-015 While rst_n is 0 at a rising edge, the block SHALL go to IDLE and clear these registers to 0: s, cout, the slice counter and the carry register.
REQ-016 A reset during BUSY or DONE SHALL abandon the operation without producing a result.
REQ-017 After release, in_ready SHALL be 1 and out_valid SHALL be 0.

Configuration
REQ-018 With ALU_SERIAL_ZERO_FLAG_EN defined, the block SHALL add an output port zero (1 bit).
- zero SHALL be 1 when the completed s equals 0, valid with out_valid, and reset to 0.
- It SHALL be accumulated per slice, not computed by a 64-bit compare at the end.
REQ-019 Without ALU_SERIAL_ZERO_FLAG_EN, the zero port and its logic SHALL be absent.
- All other behaviour SHALL be identical with or without the macro.

Structure
REQ-020 Package alu_pkg SHALL hold the following:
- enum alu_op_e (NOR, XOR, ADD, SUB)
- SLICE_W=16
- NUM_SLICES=4
- the FSM state enum
REQ-021 One combinational sub-module, alu16bit_slice, SHALL implement a 16-bit NOR/XOR/ADD/SUB with ports a, b, cin, op, s and cout.
- It SHALL be instantiated once and time-shared across slices.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD: a=0x8000_0000_0000_0000, b=1, cin=0 -> s=0x8000_0000_0000_0001, cout=0, out_valid exactly 4 cycles after acceptance.
- SUB: same operands, cin=0 -> s=0x7FFF_FFFF_FFFF_FFFE, cout=1; with cin=1 -> s=0x7FFF_FFFF_FFFF_FFFF, cout=1.
- Cross-slice carry: ADD a=0x0000_0000_0000_FFFF, b=1, cin=0 -> s=0x0000_0000_0001_0000, cout=0; ADD a=all-ones, b=1 -> s=0, cout=1 (zero=1 with macro).
- Logic ops: NOR a=0, b=0 -> s=all-ones, cout=0; XOR a=0xF0F0_F0F0_F0F0_F0F0, b=all-ones -> s=0x0F0F_0F0F_0F0F_0F0F, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> s and cout stable, in_ready=0, no second acceptance; after out_ready=1, IDLE, then the new request is accepted.
- Reset mid-op: rst_n=0 at edge N+2 -> next cycle IDLE, s=0, cout=0, out_valid=0, in_ready=1; a following ADD completes correctly.
